// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: re-phasable baud clock, receiver drain, byte FIFO.
// Optional sticky overrun flag enabled by defining UART_RX_CTRL_OVR_EN.
module uart_rx_ctrl #(
  parameter int WIDTH_DATA = 8,
  parameter int DIV        = 16,
  parameter int AW         = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_clk_rx,
  input  logic                  i_srst_clk,
  input  logic                  i_rx_rdy,
  input  logic [WIDTH_DATA-1:0] i_rx_data,
  output logic                  o_rx_re,
  output logic                  o_valid,
  output logic [WIDTH_DATA-1:0] o_data,
  input  logic                  i_ready,
  output logic [AW:0]           o_count,
  output logic                  o_full,
  output logic                  o_ovr,
  input  logic                  i_ovr_clr
);

  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int NW    = AW + 1;
  localparam int DEPTH = 2 ** AW;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
  localparam logic [NW-1:0] OCC_FULL = NW'(DEPTH);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  clk_rx_q, clk_rx_d;
  logic                  re_q, re_d;
  logic [AW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic [NW-1:0]         count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  full_q, full_d;
  logic [WIDTH_DATA-1:0] mem_q [DEPTH];
  logic                  push, pop, wr_en, drop;

  // Clock output is computed from the next count so it tracks cnt >= DIV/2 exactly.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_srst_clk) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
    clk_rx_d = (cnt_d >= CNT_HALF);
  end

  always_comb begin
    re_d  = i_rx_rdy && !re_q;
    push  = re_d;
    pop   = valid_q && i_ready;
    wr_en = push && (!full_q || pop);
    drop  = push && full_q && !pop;

    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (wr_en) wp_d = wp_q + 1'b1;
    if (pop)   rp_d = rp_q + 1'b1;
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !wr_en) begin
      count_d = count_q - 1'b1;
    end
    valid_d = (count_d != '0);
    full_d  = (count_d == OCC_FULL);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q    <= '0;
      clk_rx_q <= 1'b0;
      re_q     <= 1'b0;
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      clk_rx_q <= clk_rx_d;
      re_q     <= re_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wp_q] <= i_rx_data;
  end

  assign o_clk_rx = clk_rx_q;
  assign o_rx_re  = re_q;
  assign o_valid  = valid_q;
  assign o_data   = mem_q[rp_q];
  assign o_count  = count_q;
  assign o_full   = full_q;

`ifdef UART_RX_CTRL_OVR_EN
  logic ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (drop) begin
      ovr_d = 1'b1;
    end else if (i_ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ovr_q <= 1'b0;
    else       ovr_q <= ovr_d;
  end

  assign o_ovr = ovr_q;
`else
  logic unused_ovr;
  assign unused_ovr = i_ovr_clr | drop;
  assign o_ovr      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_uart_rx_ctrl;

  localparam int WD    = 8;
  localparam int DIV   = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 2 ** AW;

  logic          i_clk, i_rst;
  logic          o_clk_rx, i_srst_clk;
  logic          i_rx_rdy;
  logic [WD-1:0] i_rx_data;
  logic          o_rx_re, o_valid;
  logic [WD-1:0] o_data;
  logic          i_ready;
  logic [AW:0]   o_count;
  logic          o_full, o_ovr, i_ovr_clr;

  uart_rx_ctrl #(.WIDTH_DATA(WD), .DIV(DIV), .AW(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .o_clk_rx(o_clk_rx), .i_srst_clk(i_srst_clk),
    .i_rx_rdy(i_rx_rdy), .i_rx_data(i_rx_data), .o_rx_re(o_rx_re),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready), .o_count(o_count),
    .o_full(o_full), .o_ovr(o_ovr), .i_ovr_clr(i_ovr_clr)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks   = 0;
  int failures = 0;

  // Model: edges since last phase anchor, last read-enable, byte queue, overrun.
  int            k;
  bit            re_m, ovr_m;
  logic [WD-1:0] q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    k     = 0;
    re_m  = 1'b0;
    ovr_m = 1'b0;
    q.delete();
  endtask

  task automatic compare_all();
    check("clk_rx", 32'(o_clk_rx), ((k % DIV) >= DIV / 2) ? 32'd1 : 32'd0);
    check("rx_re",  32'(o_rx_re),  32'(re_m));
    check("valid",  32'(o_valid),  (q.size() != 0) ? 32'd1 : 32'd0);
    check("count",  32'(o_count),  32'(q.size()));
    check("full",   32'(o_full),   (q.size() == DEPTH) ? 32'd1 : 32'd0);
    check("ovr",    32'(o_ovr),    32'(ovr_m));
    if (q.size() != 0) check("data", 32'(o_data), 32'(q[0]));
  endtask

  task automatic step();
    bit push, pop, dropped;
    @(posedge i_clk);
    if (i_srst_clk) k = 0;
    else            k++;
    push    = i_rx_rdy && !re_m;
    pop     = (q.size() != 0) && i_ready;
    dropped = 1'b0;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(i_rx_data);
      else                  dropped = 1'b1;
    end
`ifdef UART_RX_CTRL_OVR_EN
    if (dropped)        ovr_m = 1'b1;
    else if (i_ovr_clr) ovr_m = 1'b0;
`endif
    re_m = push;
    #1;
    compare_all();
  endtask

  task automatic push_byte(input logic [WD-1:0] b);
    i_rx_rdy  = 1'b1;
    i_rx_data = b;
    step();
    i_rx_rdy  = 1'b0;
    step();
  endtask

  task automatic drain();
    int n = 0;
    i_ready = 1'b1;
    while (q.size() != 0 && n < 2 * DEPTH) begin
      step();
      n++;
    end
    i_ready = 1'b0;
    check("drain_empty", 32'(o_valid), 32'd0);
  endtask

  logic [WD-1:0] exp_order [4];

  initial begin
    int n;
    i_rst = 1'b1; i_srst_clk = 1'b0; i_rx_rdy = 1'b0; i_rx_data = '0;
    i_ready = 1'b0; i_ovr_clr = 1'b0;
    model_reset();
    #12;
    compare_all();
    i_rst = 1'b0;

    // Free-running baud clock
    for (int i = 0; i < 3 * DIV; i++) step();

    // Re-phase at cnt=5
    n = 0;
    while ((k % DIV) != 5 && n < 2 * DIV) begin step(); n++; end
    check("phase_at5", 32'(k % DIV), 32'd5);
    i_srst_clk = 1'b1;
    step();
    i_srst_clk = 1'b0;
    check("srst_low", 32'(o_clk_rx), 32'd0);
    for (int i = 0; i < 2 * DIV + 2; i++) step();

    // Held ready flag yields a single drain
    i_rx_rdy = 1'b1; i_rx_data = 8'hA5;
    step();
    check("a5_re", 32'(o_rx_re), 32'd1);
    step();
    check("a5_re_once", 32'(o_rx_re), 32'd0);
    i_rx_rdy = 1'b0;
    step();
    check("a5_data", 32'(o_data), 32'hA5);
    check("a5_count", 32'(o_count), 32'd1);
    drain();

    // Fill, overrun, then pop in order
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    check("fill_full", 32'(o_full), 32'd1);
    check("fill_count", 32'(o_count), 32'd4);
`ifdef UART_RX_CTRL_OVR_EN
    check("fill_ovr", 32'(o_ovr), 32'd1);
`else
    check("fill_ovr", 32'(o_ovr), 32'd0);
`endif
    check("fill_head", 32'(o_data), 32'h01);

    // Full with simultaneous pop accepts the push
    i_ready = 1'b1; i_rx_rdy = 1'b1; i_rx_data = 8'h06;
    step();
    i_ready = 1'b0; i_rx_rdy = 1'b0;
    step();
    check("pp_count", 32'(o_count), 32'd4);
    exp_order[0] = 8'h02; exp_order[1] = 8'h03; exp_order[2] = 8'h04; exp_order[3] = 8'h06;
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pp_order", 32'(o_data), 32'(exp_order[i]));
      step();
    end
    i_ready = 1'b0;
    check("pp_empty", 32'(o_count), 32'd0);

    // Clear overrun
    i_ovr_clr = 1'b1;
    step();
    i_ovr_clr = 1'b0;
    check("ovr_cleared", 32'(o_ovr), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      i_rx_rdy   = ($urandom_range(0, 2) == 0);
      i_rx_data  = 8'($urandom);
      i_ready    = ($urandom_range(0, 3) == 0);
      i_srst_clk = ($urandom_range(0, 49) == 0);
      i_ovr_clr  = ($urandom_range(0, 7) == 0);
      step();
    end
    i_rx_rdy = 1'b0; i_ready = 1'b0; i_srst_clk = 1'b0; i_ovr_clr = 1'b0;
    step();
    drain();

    // Asynchronous reset with bytes queued and baud clock high
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    n = 0;
    while ((k % DIV) < DIV / 2 && n < 2 * DIV) begin step(); n++; end
    check("pre_rst_clk", 32'(o_clk_rx), 32'd1);
    check("pre_rst_count", 32'(o_count), 32'd3);
    #2;
    i_rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1;
    i_rst = 1'b0;
    push_byte(8'h3C);
    check("post_rst_data", 32'(o_data), 32'h3C);
    check("post_rst_count", 32'(o_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART receiver. It generates the receiver's baud sampling clock and re-phases it on every start-bit detect so that samples fall mid-bit. It drains each received byte from the receiver via its read-enable handshake into a small FIFO. Downstream logic pops bytes through a valid/ready interface, and the block flags overruns.

## Interface
Parameters:
- `WIDTH_DATA`, 8, byte width; matches the receiver.
- `DIV`, 16, `i_clk` cycles per bit; even, ≥ 4.
- `AW`, 2, FIFO address width; depth = 2**AW.

Ports:
- `i_clk`  in  1  system clock; the block's only clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `o_clk_rx`  out  1  baud sampling clock to the receiver; the receiver samples on its rising edge.
- `i_srst_clk`  in  1  start-detect pulse from the receiver; re-phases the baud clock.
- `i_rx_rdy`  in  1  receiver byte-ready flag.
- `i_rx_data`  in  WIDTH_DATA  receiver byte.
- `o_rx_re`  out  1  one-cycle read-enable pulse to the receiver; clears its ready flag.
- `o_valid`  out  1  FIFO non-empty.
- `o_data`  out  WIDTH_DATA  FIFO head byte (fall-through).
- `i_ready`  in  1  consumer pop; a pop occurs when `o_valid && i_ready`.
- `o_count`  out  AW+1  FIFO occupancy, 0..2**AW.
- `o_full`  out  1  occupancy = 2**AW.
- `o_ovr`  out  1  sticky overrun flag (see Configuration).
- `i_ovr_clr`  in  1  clears `o_ovr`.

## Operation
- **Baud generator**
  - Counter `cnt` runs 0..DIV-1 and wraps to 0.
  - `o_clk_rx` is registered and equals 1 while `cnt ≥ DIV/2`.
  - When `i_srst_clk` = 1: `cnt` ← 0 and `o_clk_rx` ← 0 on the next edge.
  - The first rising edge then falls DIV/2 cycles after the pulse (mid start bit); subsequent rising edges come every DIV cycles.
  - `i_srst_clk` overrides the wrap.
- **Drain**
  - If `i_rx_rdy` = 1 and `o_rx_re` = 0: `o_rx_re` ← 1 for exactly one cycle, and `i_rx_data` is pushed into the FIFO in the same edge.
  - The `o_rx_re` = 0 guard prevents a double push while the receiver's ready flag is still clearing.
  - `o_rx_re` is never high two consecutive cycles.
- **FIFO**
  - Circular buffer, depth 2**AW, with AW-bit read/write pointers that wrap modulo depth.
  - `o_count` is held as a separate AW+1-bit counter.
  - Push with room: write `mem[wp]`, wp+1, count+1.
  - Pop: rp+1, count−1.
  - Simultaneous push and pop: both execute and count is unchanged. This also applies when the FIFO is full, where the push is accepted because the pop frees a slot.
  - Push when full with no pop: the byte is dropped, pointers and count are unchanged, and an overrun event occurs.
  - Pop when empty: ignored.
- `o_data` = `mem[rp]`; its value is undefined when `o_valid` = 0.

## Timing
- Reset values: `o_clk_rx` = 0, `cnt` = 0, `o_rx_re` = 0, `o_valid` = 0, `o_count` = 0, `o_full` = 0, `o_ovr` = 0. FIFO memory is not reset.
- Reset is asynchronous. Asserting it mid-frame or mid-pop discards FIFO contents immediately.
- Drain latency:
  - `i_rx_rdy` rising at cycle n gives `o_rx_re` = 1 at n+1.
  - The byte is visible at `o_data` with `o_valid` = 1 from n+1 if the FIFO was empty.
- `o_count`, `o_full` and `o_valid` are registered and update on the edge of the push/pop.
- Overrun priority: a set in the same cycle as `i_ovr_clr` wins.

## Configuration
- `UART_RX_CTRL_OVR_EN` defined:
  - `o_ovr` is set on any dropped push.
  - It holds until `i_ovr_clr` is asserted with no concurrent overrun.
- `UART_RX_CTRL_OVR_EN` undefined:
  - `o_ovr` is tied to 0 and `i_ovr_clr` is ignored.
  - Drop-on-full behaviour is unchanged.

## Test plan
- Reset, DIV=16, no `i_srst_clk` -> `o_clk_rx` is a 16-cycle period square wave, high for cycles 8..15 of each period.
- Pulse `i_srst_clk` at `cnt`=5 -> `o_clk_rx` is low on the next edge and rises 8 cycles after the pulse, then every 16 cycles.
- `i_rx_rdy` held high for 2 cycles with `i_rx_data`=0xA5, FIFO empty -> exactly one `o_rx_re` pulse, `o_valid`=1, `o_data`=0xA5, `o_count`=1.
- AW=2, push 0x01..0x04 with `i_ready`=0, then push 0x05 -> `o_full`=1, `o_count`=4, 0x05 dropped, `o_ovr`=1 when the macro is defined (0 when undefined); then pops return 0x01..0x04 in order.
- FIFO full, push 0x06 in the same cycle as a pop -> 0x06 accepted, `o_count` stays 4, `o_ovr` unchanged; wrap-around order is preserved.
- Assert `i_rst` with 3 bytes queued and `o_clk_rx` high -> all outputs return to their reset values immediately; a later push of 0x3C reads back as 0x3C.
